id_ex_operand_stage: RTL and testbench

- ID→EX pipeline stage that consumes the two register-file read ports and produces registered EX-stage operands.
- Resolves RAW hazards by forwarding from EX and MEM results.
- Detects load-use hazards, raises a decode stall for that cycle and inserts a bubble into EX.
- Honours a flush from branch/jump resolution and a hold from downstream stages.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/id_ex_operand_stage_if.sv | 50 +++++
 rtl/fwd_mux.sv | 32 +++
 rtl/id_ex_operand_stage.sv | 101 ++++++++++
 tb/tb_id_ex_operand_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath constants and ALU opcode encodings
package cpu_pkg;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int OPW = 4;

  localparam logic [AW-1:0] REG_ZERO = '0;

  localparam logic [OPW-1:0] ALU_ADD  = 4'h0;
  localparam logic [OPW-1:0] ALU_SUB  = 4'h1;
  localparam logic [OPW-1:0] ALU_AND  = 4'h2;
  localparam logic [OPW-1:0] ALU_OR   = 4'h3;
  localparam logic [OPW-1:0] ALU_XOR  = 4'h4;
  localparam logic [OPW-1:0] ALU_NOR  = 4'h5;
  localparam logic [OPW-1:0] ALU_SLT  = 4'h6;
  localparam logic [OPW-1:0] ALU_SLTU = 4'h7;
  localparam logic [OPW-1:0] ALU_SLL  = 4'h8;
  localparam logic [OPW-1:0] ALU_SRL  = 4'h9;
  localparam logic [OPW-1:0] ALU_SRA  = 4'hA;
  localparam logic [OPW-1:0] ALU_LUI  = 4'hB;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - decode-side inputs and EX-side outputs of the operand stage
interface id_ex_operand_stage_if #(
  parameter int DW  = cpu_pkg::DW,
  parameter int AW  = cpu_pkg::AW,
  parameter int OPW = cpu_pkg::OPW
);

  logic           id_valid;
  logic [AW-1:0]  id_rs;
  logic [AW-1:0]  id_rt;
  logic           id_uses_rs;
  logic           id_uses_rt;
  logic [AW-1:0]  id_dest;
  logic           id_we;
  logic           id_mem_rd;
  logic [OPW-1:0] id_alu_op;
  logic [DW-1:0]  id_imm;
  logic [DW-1:0]  rf_rdata1;
  logic [DW-1:0]  rf_rdata2;
  logic [DW-1:0]  ex_alu_result;
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [DW-1:0]  mem_wdata;
  logic           flush;
  logic           ex_hold;
  logic           id_stall;
  logic           ex_valid;
  logic [DW-1:0]  ex_a;
  logic [DW-1:0]  ex_b;
  logic [DW-1:0]  ex_imm;
  logic [OPW-1:0] ex_alu_op;
  logic [AW-1:0]  ex_dest;
  logic           ex_we;
  logic           ex_mem_rd;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_we, id_mem_rd,
           id_alu_op, id_imm, rf_rdata1, rf_rdata2, ex_alu_result, mem_we, mem_waddr,
           mem_wdata, flush, ex_hold,
    input  id_stall, ex_valid, ex_a, ex_b, ex_imm, ex_alu_op, ex_dest, ex_we, ex_mem_rd
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_we, id_mem_rd,
           id_alu_op, id_imm, rf_rdata1, rf_rdata2, ex_alu_result, mem_we, mem_waddr,
           mem_wdata, flush, ex_hold,
    output id_stall, ex_valid, ex_a, ex_b, ex_imm, ex_alu_op, ex_dest, ex_we, ex_mem_rd
  );

endinterface

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - one-operand forwarding select (EX over MEM over regfile, r0 pinned to zero)
module fwd_mux #(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW
) (
  input  logic [AW-1:0] src,
  input  logic          ex_valid,
  input  logic          ex_we,
  input  logic          ex_mem_rd,
  input  logic [AW-1:0] ex_dest,
  input  logic [DW-1:0] ex_alu_result,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] rf_rdata,
  output logic [DW-1:0] operand
);
  import cpu_pkg::*;

  // A load in EX has no data yet; that case is handled by the load-use bubble.
  always_comb begin
    operand = rf_rdata;
    if (src == AW'(REG_ZERO)) begin
      operand = '0;
    end else if (ex_valid && ex_we && !ex_mem_rd && (ex_dest == src)) begin
      operand = ex_alu_result;
    end else if (mem_we && (mem_waddr == src)) begin
      operand = mem_wdata;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID->EX register stage with forwarding, load-use bubble, flush and hold
module id_ex_operand_stage #(
  parameter int DW  = cpu_pkg::DW,
  parameter int AW  = cpu_pkg::AW,
  parameter int OPW = cpu_pkg::OPW
) (
  input  logic                  clk,
  input  logic                  rst,
  id_ex_operand_stage_if.slave  bus
);
  import cpu_pkg::*;

  logic           ex_valid_q;
  logic [DW-1:0]  ex_a_q;
  logic [DW-1:0]  ex_b_q;
  logic [DW-1:0]  ex_imm_q;
  logic [OPW-1:0] ex_alu_op_q;
  logic [AW-1:0]  ex_dest_q;
  logic           ex_we_q;
  logic           ex_mem_rd_q;

  logic [DW-1:0]  fwd_a;
  logic [DW-1:0]  fwd_b;
  logic           load_use;

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .src           (bus.id_rs),
    .ex_valid      (ex_valid_q),
    .ex_we         (ex_we_q),
    .ex_mem_rd     (ex_mem_rd_q),
    .ex_dest       (ex_dest_q),
    .ex_alu_result (bus.ex_alu_result),
    .mem_we        (bus.mem_we),
    .mem_waddr     (bus.mem_waddr),
    .mem_wdata     (bus.mem_wdata),
    .rf_rdata      (bus.rf_rdata1),
    .operand       (fwd_a)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .src           (bus.id_rt),
    .ex_valid      (ex_valid_q),
    .ex_we         (ex_we_q),
    .ex_mem_rd     (ex_mem_rd_q),
    .ex_dest       (ex_dest_q),
    .ex_alu_result (bus.ex_alu_result),
    .mem_we        (bus.mem_we),
    .mem_waddr     (bus.mem_waddr),
    .mem_wdata     (bus.mem_wdata),
    .rf_rdata      (bus.rf_rdata2),
    .operand       (fwd_b)
  );

  always_comb begin
    load_use = bus.id_valid && ex_valid_q && ex_mem_rd_q && ex_we_q &&
               (ex_dest_q != AW'(REG_ZERO)) &&
               ((bus.id_uses_rs && (ex_dest_q == bus.id_rs)) ||
                (bus.id_uses_rt && (ex_dest_q == bus.id_rt)));
  end

  assign bus.id_stall = bus.ex_hold | (load_use & ~bus.flush);

  // Bubbles clear only the control bits; data fields keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_imm_q    <= '0;
      ex_alu_op_q <= '0;
      ex_dest_q   <= '0;
      ex_we_q     <= 1'b0;
      ex_mem_rd_q <= 1'b0;
    end else if (bus.ex_hold) begin
      ex_valid_q  <= ex_valid_q;
    end else if (bus.flush || load_use) begin
      ex_valid_q  <= 1'b0;
      ex_we_q     <= 1'b0;
      ex_mem_rd_q <= 1'b0;
    end else begin
      ex_valid_q  <= bus.id_valid;
      ex_a_q      <= fwd_a;
      ex_b_q      <= fwd_b;
      ex_imm_q    <= bus.id_imm;
      ex_alu_op_q <= bus.id_alu_op;
      ex_dest_q   <= bus.id_dest;
      ex_we_q     <= bus.id_we;
      ex_mem_rd_q <= bus.id_mem_rd;
    end
  end

  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_a      = ex_a_q;
  assign bus.ex_b      = ex_b_q;
  assign bus.ex_imm    = ex_imm_q;
  assign bus.ex_alu_op = ex_alu_op_q;
  assign bus.ex_dest   = ex_dest_q;
  assign bus.ex_we     = ex_we_q;
  assign bus.ex_mem_rd = ex_mem_rd_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed table plus randomized model check of id_ex_operand_stage
module tb_id_ex_operand_stage;
  import cpu_pkg::*;

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic [4:0]  dest;
    logic        we, mrd;
    logic [3:0]  op;
    logic [31:0] imm, rf1, rf2, exr;
    logic        mwe;
    logic [4:0]  mwa;
    logic [31:0] mwd;
    logic        flush, hold;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        stall;
    logic        valid;
    logic [31:0] a, b;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  // expected EX-stage contents, maintained from the spec rules
  logic        m_valid, m_we, m_mrd;
  logic [31:0] m_a, m_b, m_imm;
  logic [3:0]  m_op;
  logic [4:0]  m_dest;

  vec_t tbl[18];

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic stim_t st(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                               logic [4:0] dest, logic we, logic mrd, logic [31:0] rf1,
                               logic [31:0] rf2, logic [31:0] exr, logic mwe, logic [4:0] mwa,
                               logic [31:0] mwd, logic flush, logic hold);
    stim_t s;
    s.v = v; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt; s.dest = dest;
    s.we = we; s.mrd = mrd; s.op = mrd ? ALU_ADD : ALU_SUB;
    s.imm = 32'h1000 + {27'h0, dest};
    s.rf1 = rf1; s.rf2 = rf2; s.exr = exr;
    s.mwe = mwe; s.mwa = mwa; s.mwd = mwd; s.flush = flush; s.hold = hold;
    return s;
  endfunction

  function automatic vec_t mkv(stim_t s, logic stall, logic valid, logic [31:0] a, logic [31:0] b);
    vec_t t;
    t.s = s; t.stall = stall; t.valid = valid; t.a = a; t.b = b;
    return t;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.v = ($urandom_range(0, 9) != 0);
    s.rs = 5'($urandom_range(0, 7));
    s.rt = 5'($urandom_range(0, 7));
    s.urs = ($urandom_range(0, 4) != 0);
    s.urt = ($urandom_range(0, 2) != 0);
    s.dest = 5'($urandom_range(0, 7));
    s.we = ($urandom_range(0, 4) != 0);
    s.mrd = ($urandom_range(0, 2) == 0);
    s.op = 4'($urandom_range(0, 11));
    s.imm = $urandom; s.rf1 = $urandom; s.rf2 = $urandom; s.exr = $urandom;
    s.mwe = ($urandom_range(0, 1) != 0);
    s.mwa = 5'($urandom_range(0, 7));
    s.mwd = $urandom;
    s.flush = ($urandom_range(0, 9) == 0);
    s.hold = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.id_valid = s.v; bus.id_rs = s.rs; bus.id_rt = s.rt;
    bus.id_uses_rs = s.urs; bus.id_uses_rt = s.urt; bus.id_dest = s.dest;
    bus.id_we = s.we; bus.id_mem_rd = s.mrd; bus.id_alu_op = s.op; bus.id_imm = s.imm;
    bus.rf_rdata1 = s.rf1; bus.rf_rdata2 = s.rf2; bus.ex_alu_result = s.exr;
    bus.mem_we = s.mwe; bus.mem_waddr = s.mwa; bus.mem_wdata = s.mwd;
    bus.flush = s.flush; bus.ex_hold = s.hold;
  endtask

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_mrd = 0; m_a = 0; m_b = 0; m_imm = 0; m_op = 0; m_dest = 0;
  endtask

  // Value the instruction in decode should see for register r: the youngest in-flight producer.
  function automatic logic [31:0] ref_operand(logic [4:0] r, logic [31:0] rf, stim_t s);
    if (r == 0) return 32'h0;
    if (m_valid && m_we && !m_mrd && m_dest == r) return s.exr;
    if (s.mwe && s.mwa == r) return s.mwd;
    return rf;
  endfunction

  function automatic logic ref_load_use(stim_t s);
    logic reads_load;
    reads_load = (s.urs && s.rs == m_dest) || (s.urt && s.rt == m_dest);
    return s.v && m_valid && m_we && m_mrd && (m_dest != 0) && reads_load;
  endfunction

  task automatic step(input stim_t s, output logic stall_seen);
    logic lu;
    logic [31:0] na, nb;
    apply(s);
    #1;
    stall_seen = bus.id_stall;
    lu = ref_load_use(s);
    chk("id_stall", {31'h0, bus.id_stall}, {31'h0, s.hold | (lu & ~s.flush)});
    na = ref_operand(s.rs, s.rf1, s);
    nb = ref_operand(s.rt, s.rf2, s);
    if (!s.hold) begin
      if (s.flush || lu) begin
        m_valid = 0; m_we = 0; m_mrd = 0;
      end else begin
        m_valid = s.v; m_we = s.we; m_mrd = s.mrd; m_a = na; m_b = nb;
        m_imm = s.imm; m_op = s.op; m_dest = s.dest;
      end
    end
    @(posedge clk);
    #1;
    chk("ex_valid", {31'h0, bus.ex_valid}, {31'h0, m_valid});
    chk("ex_we", {31'h0, bus.ex_we}, {31'h0, m_we});
    chk("ex_mem_rd", {31'h0, bus.ex_mem_rd}, {31'h0, m_mrd});
    if (m_valid) begin
      chk("ex_a", bus.ex_a, m_a);
      chk("ex_b", bus.ex_b, m_b);
      chk("ex_imm", bus.ex_imm, m_imm);
      chk("ex_alu_op", {28'h0, bus.ex_alu_op}, {28'h0, m_op});
      chk("ex_dest", {27'h0, bus.ex_dest}, {27'h0, m_dest});
    end
    @(negedge clk);
  endtask

  initial begin
    logic  stall;
    stim_t idle;

    //            v rs rt us ut dst we ld  rf1          rf2      exr          mwe mwa mwd           fl ho   stall val a             b
    tbl[0]  = mkv(st(1, 1, 2, 1, 1, 3, 1, 0, 32'h1,       32'h2,  32'h0,       0, 0, 32'h0,         0, 0), 0, 1, 32'h1,        32'h2);
    tbl[1]  = mkv(st(1, 3, 1, 1, 1, 7, 1, 0, 32'h5,       32'h9,  32'h11,      0, 0, 32'h0,         0, 0), 0, 1, 32'h11,       32'h9);
    tbl[2]  = mkv(st(1, 1, 4, 1, 1, 8, 1, 0, 32'h1,       32'h3,  32'h77,      1, 4, 32'hAAAA0000,  0, 0), 0, 1, 32'h1,        32'hAAAA0000);
    tbl[3]  = mkv(st(1, 0, 0, 1, 1, 4, 1, 0, 32'h55,      32'h66, 32'h88,      0, 0, 32'h0,         0, 0), 0, 1, 32'h0,        32'h0);
    tbl[4]  = mkv(st(1, 2, 4, 1, 1, 9, 1, 0, 32'h22,      32'h33, 32'h1234,    1, 4, 32'hAAAA0000,  0, 0), 0, 1, 32'h22,       32'h1234);
    tbl[5]  = mkv(st(1, 1, 0, 1, 0, 5, 1, 1, 32'h100,     32'h0,  32'h99,      0, 0, 32'h0,         0, 0), 0, 1, 32'h100,      32'h0);
    tbl[6]  = mkv(st(1, 5, 1, 1, 1, 6, 1, 0, 32'h5555,    32'h1,  32'h104,     0, 0, 32'h0,         0, 0), 1, 0, 32'h0,        32'h0);
    tbl[7]  = mkv(st(1, 5, 1, 1, 1, 6, 1, 0, 32'h5555,    32'h1,  32'h0,       1, 5, 32'hDEADBEEF,  0, 0), 0, 1, 32'hDEADBEEF, 32'h1);
    tbl[8]  = mkv(st(1, 2, 0, 1, 0, 0, 1, 1, 32'h10,      32'h0,  32'h3,       0, 0, 32'h0,         0, 0), 0, 1, 32'h10,       32'h0);
    tbl[9]  = mkv(st(1, 0, 0, 1, 1, 10, 1, 0, 32'h5,      32'h6,  32'hFFFF,    1, 0, 32'h77,        0, 0), 0, 1, 32'h0,        32'h0);
    tbl[10] = mkv(st(1, 1, 0, 1, 0, 5, 1, 1, 32'h200,     32'h0,  32'h20,      0, 0, 32'h0,         0, 0), 0, 1, 32'h200,      32'h0);
    tbl[11] = mkv(st(1, 5, 1, 1, 1, 6, 1, 0, 32'h5,       32'h1,  32'h204,     0, 0, 32'h0,         1, 0), 0, 0, 32'h0,        32'h0);
    tbl[12] = mkv(st(1, 1, 2, 1, 1, 11, 1, 0, 32'hA,      32'hB,  32'h0,       0, 0, 32'h0,         0, 0), 0, 1, 32'hA,        32'hB);
    tbl[13] = mkv(st(1, 3, 4, 1, 1, 12, 1, 0, 32'hFF,     32'hFF, 32'h15,      0, 0, 32'h0,         0, 1), 1, 1, 32'hA,        32'hB);
    tbl[14] = mkv(st(1, 3, 4, 1, 1, 12, 1, 0, 32'hFF,     32'hFF, 32'h15,      0, 0, 32'h0,         0, 1), 1, 1, 32'hA,        32'hB);
    tbl[15] = mkv(st(1, 3, 4, 1, 1, 12, 1, 0, 32'hFF,     32'hFF, 32'h15,      0, 0, 32'h0,         1, 1), 1, 1, 32'hA,        32'hB);
    tbl[16] = mkv(st(1, 3, 4, 1, 1, 12, 1, 0, 32'hFF,     32'hFF, 32'h15,      0, 0, 32'h0,         1, 0), 0, 0, 32'h0,        32'h0);
    tbl[17] = mkv(st(1, 1, 2, 1, 1, 13, 1, 0, 32'h3C,     32'h4C, 32'h0,       0, 0, 32'h0,         0, 0), 0, 1, 32'h3C,       32'h4C);

    idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(idle);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset ex_valid", {31'h0, bus.ex_valid}, 32'h0);
    chk("reset ex_we", {31'h0, bus.ex_we}, 32'h0);
    chk("reset ex_a", bus.ex_a, 32'h0);
    chk("reset id_stall", {31'h0, bus.id_stall}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].s, stall);
      chk($sformatf("tbl%0d stall", i), {31'h0, stall}, {31'h0, tbl[i].stall});
      chk($sformatf("tbl%0d valid", i), {31'h0, bus.ex_valid}, {31'h0, tbl[i].valid});
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d ex_a", i), bus.ex_a, tbl[i].a);
        chk($sformatf("tbl%0d ex_b", i), bus.ex_b, tbl[i].b);
      end
    end

    // asynchronous reset in the middle of a cycle, with a load in EX
    step(st(1, 1, 2, 1, 1, 5, 1, 1, 32'hCAFE, 32'h1, 0, 0, 0, 0, 0, 0), stall);
    chk("pre-reset ex_valid", {31'h0, bus.ex_valid}, 32'h1);
    apply(st(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    chk("async rst ex_valid", {31'h0, bus.ex_valid}, 32'h0);
    chk("async rst ex_we", {31'h0, bus.ex_we}, 32'h0);
    chk("async rst ex_a", bus.ex_a, 32'h0);
    chk("async rst id_stall", {31'h0, bus.id_stall}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 500; i++) begin
      step(rnd_stim(), stall);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
